// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and halt sequencing for a 5-stage pipeline.
// Macro FWD_EN enables EX/MEM/WB forwarding; without it every in-flight dependence stalls.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst,
  input  logic                          id_we,
  input  logic                          id_is_load,
  input  logic                          id_hlt,
  input  logic                          ex_redirect,
  output logic                          stall_if_id,
  output logic                          bubble_ex,
  output logic                          flush_if_id,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          hlt,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] dst;
    logic                  is_load;
  } entry_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state;
  entry_t ex, mem, wb;
  logic [NUM_SRC-1:0] m_ex, m_mem, m_wb;
  logic run, hazard, hstall, issue, unused_ok;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [REG_ADDR_W-1:0] s;
    assign s = id_src[g*REG_ADDR_W +: REG_ADDR_W];
    assign m_ex[g] = id_src_used[g] & ex.valid & ex.we & (ex.dst == s) & (|s);
    assign m_mem[g] = id_src_used[g] & mem.valid & mem.we & (mem.dst == s) & (|s);
    assign m_wb[g] = id_src_used[g] & wb.valid & wb.we & (wb.dst == s) & (|s);
`ifdef FWD_EN
    assign fwd_sel[2*g +: 2] = m_ex[g] ? 2'b01 : m_mem[g] ? 2'b10 : m_wb[g] ? 2'b11 : 2'b00;
`else
    assign fwd_sel[2*g +: 2] = 2'b00;
`endif
  end
`ifdef FWD_EN
  assign hazard = id_valid & ex.is_load & (|m_ex);
`else
  assign hazard = id_valid & (|(m_ex | m_mem | m_wb));
`endif
  assign unused_ok = ^{ex.is_load, mem.is_load, wb.is_load};
  assign run = state == RUN;
  assign hstall = run & hazard & !ex_redirect;
  assign issue = run & id_valid & !hazard & !ex_redirect;
  assign flush_if_id = run & ex_redirect;
  assign stall_if_id = !run | hstall;
  assign bubble_ex = !run | ex_redirect | hazard;
  assign hlt = state == HALTED;
  // DRAIN ends once the shadow about to be loaded is empty, i.e. HLT has left WB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex <= issue ? {1'b1, id_we & !id_hlt, id_dst, id_is_load} : '0;
      mem <= ex;
      wb <= mem;
      if (hstall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_if_id && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      if (issue && id_hlt) state <= DRAIN;
      else if (state == DRAIN && !ex.valid && !mem.valid) state <= HALTED;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against an in-bench model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  localparam int RW = 4, NS = 2, CW = 4, CMAX = (1 << CW) - 1;
  logic clk = 0, rst_n = 0, id_valid = 0, id_we = 0, id_is_load = 0, id_hlt = 0, ex_redirect = 0;
  logic [NS*RW-1:0] id_src = '0;
  logic [NS-1:0] id_src_used = '0;
  logic [RW-1:0] id_dst = '0;
  logic stall_if_id, bubble_ex, flush_if_id, hlt;
  logic [2*NS-1:0] fwd_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .NUM_SRC(NS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_we(id_we), .id_is_load(id_is_load), .id_hlt(id_hlt),
    .ex_redirect(ex_redirect), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .fwd_sel(fwd_sel), .hlt(hlt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt));
  typedef struct { bit v; bit w; int d; bit ld; } ent_t;
  ent_t pipe[3];
  int mstate, m_stall, m_flush;
  bit m_issue, m_hstall, m_flushc;
`ifdef FWD_EN
  localparam bit FWD = 1;
`else
  localparam bit FWD = 0;
`endif
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  function automatic int youngest(int s, bit used);
    if (!used || s == 0) return 3;
    for (int k = 0; k < 3; k++)
      if (pipe[k].v && pipe[k].w && pipe[k].d == s) return k;
    return 3;
  endfunction
  task automatic clear_model();
    for (int k = 0; k < 3; k++) pipe[k] = '{v: 0, w: 0, d: 0, ld: 0};
    mstate = 0;
    m_stall = 0;
    m_flush = 0;
  endtask
  task automatic observe();
    logic [2*NS-1:0] efwd;
    bit dep, lu, hz, es, eb, ef;
    @(negedge clk);
    efwd = '0;
    dep = 0;
    lu = 0;
    for (int i = 0; i < NS; i++) begin
      int k = youngest(int'(id_src[i*RW +: RW]), id_src_used[i]);
      if (k < 3) dep = 1;
      if (k == 0 && pipe[0].ld) lu = 1;
      if (FWD && k < 3) efwd[2*i +: 2] = 2'(k + 1);
    end
    hz = id_valid && (FWD ? lu : dep);
    if (mstate != 0) begin es = 1; eb = 1; ef = 0; end
    else if (ex_redirect) begin es = 0; eb = 1; ef = 1; end
    else begin es = hz; eb = hz; ef = 0; end
    m_issue = mstate == 0 && id_valid && !hz && !ex_redirect;
    m_hstall = mstate == 0 && hz && !ex_redirect;
    m_flushc = ef;
    chk("stall_if_id", stall_if_id, es);
    chk("bubble_ex", bubble_ex, eb);
    chk("flush_if_id", flush_if_id, ef);
    chk("fwd_sel", fwd_sel, efwd);
    chk("hlt", hlt, mstate == 2);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask
  task automatic advance();
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = m_issue ? '{v: 1, w: id_we && !id_hlt, d: int'(id_dst), ld: id_is_load} : '{v: 0, w: 0, d: 0, ld: 0};
    if (m_hstall && m_stall < CMAX) m_stall++;
    if (m_flushc && m_flush < CMAX) m_flush++;
    if (m_issue && id_hlt) mstate = 1;
    else if (mstate == 1 && !pipe[0].v && !pipe[1].v && !pipe[2].v) mstate = 2;
    #1;
  endtask
  task automatic drive(bit v, int s0, int s1, bit [1:0] u, int d, bit w, bit l, bit h, bit r);
    id_valid = v;
    id_src = {RW'(s1), RW'(s0)};
    id_src_used = u;
    id_dst = RW'(d);
    id_we = w;
    id_is_load = l;
    id_hlt = h;
    ex_redirect = r;
  endtask
  task automatic step();
    observe();
    advance();
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    clear_model();
    chk("rst_hlt", hlt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_stall", stall_if_id, 0);
    observe();
    @(posedge clk);
    #1 rst_n = 1;
  endtask
  initial begin
    #1;
    do_reset();
    // ADD r3,r1,r2 then ADD r4,r3,r1
    drive(1, 1, 2, 2'b11, 3, 1, 0, 0, 0);
    step();
    drive(1, 3, 1, 2'b11, 4, 1, 0, 0, 0);
    observe();
    chk("dep_stall", stall_if_id, !FWD);
    chk("dep_fwd", fwd_sel, FWD ? 4'b0001 : 4'b0000);
    advance();
    while (stall_if_id) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    // LW r5 then ADD r6,r5,r5
    do_reset();
    drive(1, 1, 0, 2'b01, 5, 1, 1, 0, 0);
    step();
    drive(1, 5, 5, 2'b11, 6, 1, 0, 0, 0);
    for (int c = 0; c < (FWD ? 2 : 4); c++) begin
      observe();
      chk("lu_stall", stall_if_id, c < (FWD ? 1 : 3));
      chk("lu_bubble", bubble_ex, c < (FWD ? 1 : 3));
      chk("lu_fwd", fwd_sel, (FWD && c == 1) ? 4'b1010 : 4'b0000);
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    observe();
    chk("lu_stall_cnt", stall_cnt, FWD ? 1 : 3);
    advance();
    // write r0 then read r0
    do_reset();
    drive(1, 1, 2, 2'b11, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 2'b11, 7, 1, 0, 0, 0);
    observe();
    chk("r0_stall", stall_if_id, 0);
    chk("r0_fwd", fwd_sel, 0);
    advance();
    // redirect over a load-use instruction
    do_reset();
    drive(1, 1, 0, 2'b01, 5, 1, 1, 0, 0);
    step();
    drive(1, 5, 5, 2'b11, 6, 1, 0, 0, 1);
    observe();
    chk("rd_flush", flush_if_id, 1);
    chk("rd_bubble", bubble_ex, 1);
    chk("rd_stall", stall_if_id, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    observe();
    chk("rd_flush_cnt", flush_cnt, 1);
    chk("rd_stall_cnt", stall_cnt, 0);
    advance();
    // HLT behind two ALU ops
    do_reset();
    drive(1, 0, 0, 2'b00, 1, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 2'b00, 2, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      observe();
      chk("drain_stall", stall_if_id, 1);
      chk("drain_hlt", hlt, 0);
      advance();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 2'b00, 3, 1, 0, c == 1, c == 2);
      observe();
      chk("halted_hlt", hlt, 1);
      chk("halted_flush", flush_if_id, 0);
      advance();
    end
    // randomized episodes, each ended by an asynchronous reset
    for (int e = 0; e < 20; e++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 9) < 7,
              $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0);
        step();
      end
    end
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
